// File: rtl/rsa_job_sequencer.sv
// rsa_job_sequencer: upstream feeder for the modular-exponentiation core.
// Holds the active key, buffers message words in a small FIFO, runs one core
// job at a time over start/done and returns results in order on valid/ready.
// Optional feature: define RSA_RANGE_CHECK_EN to reject words >= key_mod
// without sending them to the core.
module rsa_job_sequencer #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [WIDTH-1:0] key_exp,
    input  logic [WIDTH-1:0] key_mod,
    output logic             key_ack,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             core_start,
    output logic [WIDTH-1:0] core_base,
    output logic [WIDTH-1:0] core_exp,
    output logic [WIDTH-1:0] core_mod,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [PW:0]    DEPTH_C = (PW+1)'(FIFO_DEPTH);
    localparam logic [TW-1:0]  TLAST   = TW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] MOD_MIN = WIDTH'(2);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic [PW:0]      count;
    logic             key_valid;
    logic [WIDTH-1:0] kexp, kmod;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] head;
    logic             push, pop, key_take, range_bad, job_bad, timed_out;

    assign core_exp = kexp;
    assign core_mod = kmod;

    // Handshake qualifiers and job-rejection decision
    always_comb begin
        head      = mem[rptr];
        push      = in_valid && in_ready;
        pop       = (state == IDLE) && (count != '0) && key_valid;
        key_take  = key_load && (state == IDLE) && (count == '0);
        timed_out = (timer == TLAST);
`ifdef RSA_RANGE_CHECK_EN
        range_bad = (head >= kmod);
`else
        range_bad = 1'b0;
`endif
        job_bad   = (kmod < MOD_MIN) || range_bad;
    end

    // FIFO storage, no reset needed since count gates all reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push/pop keeps count
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Key register, loadable only while idle with nothing queued
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            kexp      <= '0;
            kmod      <= '0;
            key_ack   <= 1'b0;
        end else begin
            key_ack <= key_take;
            if (key_take) begin
                key_valid <= 1'b1;
                kexp      <= key_exp;
                kmod      <= key_mod;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic; core_done takes priority over the timeout
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = job_bad ? OUT : ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (core_done || timed_out) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs decoded from state and FIFO occupancy
    always_comb begin
        in_ready   = (count < DEPTH_C);
        core_start = (state == ISSUE);
        out_valid  = (state == OUT);
        busy       = (state != IDLE) || (count != '0);
    end

    // Job datapath: base capture, wait timer and result/error capture
    always_ff @(posedge clk) begin
        if (rst) begin
            core_base <= '0;
            out_data  <= '0;
            out_err   <= 1'b0;
            timer     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        core_base <= head;
                        if (job_bad) begin
                            out_data <= '0;
                            out_err  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                end
                WAIT: begin
                    if (core_done) begin
                        out_data <= core_result;
                        out_err  <= 1'b0;
                    end else if (timed_out) begin
                        out_data <= '0;
                        out_err  <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// Self-checking bench for rsa_job_sequencer: directed stimulus, a reference
// core that really computes b^e mod m, and a queue-based result model.
module tb_rsa_job_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_load;
    logic [31:0] key_exp, key_mod;
    logic        key_ack;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        core_start;
    logic [31:0] core_base, core_exp, core_mod;
    logic        core_done;
    logic [31:0] core_result;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic        busy;

    always #5 clk = ~clk;

    rsa_job_sequencer #(
        .WIDTH(32),
        .FIFO_DEPTH(4),
        .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst),
        .key_load(key_load), .key_exp(key_exp), .key_mod(key_mod), .key_ack(key_ack),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_start(core_start), .core_base(core_base), .core_exp(core_exp), .core_mod(core_mod),
        .core_done(core_done), .core_result(core_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .busy(busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                           input logic [31:0] m);
        logic [63:0] r, x;
        logic [31:0] ee;
        if (m == 0) return 32'd0;
        r  = 64'd1 % {32'd0, m};
        x  = {32'd0, b} % {32'd0, m};
        ee = e;
        while (ee != 0) begin
            if (ee[0]) r = (r * x) % {32'd0, m};
            x  = (x * x) % {32'd0, m};
            ee = ee >> 1;
        end
        return r[31:0];
    endfunction

    // ---------------- model state ----------------
    logic [31:0] q[$];
    logic [31:0] m_exp = '0, m_mod = '0;
    bit          ack_pend = 1'b0;
    bit          mon_en   = 1'b0;
    bit          core_dead = 1'b0;
    int          core_delay = 33;
    int          rst_gen = 0;
    int          n_out = 0;

    function automatic void expect_result(input logic [31:0] w, output logic [31:0] d,
                                          output logic e);
        bit bad;
        bad = (m_mod < 2) || core_dead;
`ifdef RSA_RANGE_CHECK_EN
        if (w >= m_mod) bad = 1'b1;
`endif
        e = bad;
        d = bad ? 32'd0 : modexp(w, m_exp, m_mod);
    endfunction

    // compare process: every negedge against the queue/key model
    initial begin
        int          sz0;
        logic [31:0] w, ed;
        logic        ee;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                sz0 = q.size();
                check("key_ack", key_ack, ack_pend);
                check("busy", busy, sz0 != 0);
                check("core_exp", core_exp, m_exp);
                check("core_mod", core_mod, m_mod);
                if (out_valid && out_ready) begin
                    if (sz0 == 0) begin
                        check("unexpected_out", 1, 0);
                    end else begin
                        w = q.pop_front();
                        expect_result(w, ed, ee);
                        check("out_data", out_data, ed);
                        check("out_err", out_err, ee);
                        n_out++;
                    end
                end
                if (rst) begin
                    q.delete();
                    m_exp    = '0;
                    m_mod    = '0;
                    ack_pend = 1'b0;
                end else begin
                    ack_pend = key_load && (sz0 == 0);
                    if (ack_pend) begin
                        m_exp = key_exp;
                        m_mod = key_mod;
                    end
                    if (in_valid && in_ready) q.push_back(in_data);
                end
            end
        end
    end

    // reference core: answers core_start with the true power after core_delay cycles
    initial begin
        logic [31:0] jb, je, jm;
        int g, d;
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(negedge clk);
            if (mon_en && core_start && !core_dead) begin
                jb = core_base; je = core_exp; jm = core_mod;
                g  = rst_gen;   d  = core_delay;
                repeat (d) @(posedge clk);
                #1;
                core_done   = 1'b1;
                core_result = modexp(jb, je, jm);
                if (g == rst_gen) check("core_base_stable", core_base, jb);
                @(posedge clk);
                #1;
                core_done = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 3000) begin tick(); k++; end
        check({name, "_idle_bound"}, k < 3000, 1);
    endtask

    task automatic wait_start(input string name);
        int k = 0;
        while (!core_start && k < 200) begin tick(); k++; end
        check({name, "_start_bound"}, k < 200, 1);
    endtask

    task automatic load_key(input logic [31:0] e, input logic [31:0] m);
        key_load = 1'b1; key_exp = e; key_mod = m;
        tick();
        key_load = 1'b0;
        check("key_ack_pulse", key_ack, 1);
        check("key_mod_latched", core_mod, m);
        tick();
        check("key_ack_single", key_ack, 0);
    endtask

    initial begin
        int k, base_out;
        bit seen;
        rst = 1'b1; key_load = 1'b0; key_exp = '0; key_mod = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        mon_en = 1'b1;
        // reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_key_ack", key_ack, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_base", core_base, 0);
        check("rst_core_exp", core_exp, 0);
        check("rst_core_mod", core_mod, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_err", out_err, 0);
        check("rst_busy", busy, 0);

        // 1: textbook RSA job with latency
        load_key(32'd17, 32'd3233);
        in_valid = 1'b1; in_data = 32'd65;
        tick();                        // N+1
        in_valid = 1'b0;
        check("t1_no_start_n1", core_start, 0);
        tick();                        // N+2
        check("t1_start_n2", core_start, 1);
        check("t1_base", core_base, 65);
        k = 0;
        while (!out_valid && k < 200) begin tick(); k++; end
        check("t1_result_latency", k, 34);
        check("t1_data", out_data, 2790);
        check("t1_err", out_err, 0);
        tick();
        check("t1_valid_drop", out_valid, 0);
        wait_idle("t1");

        // 2: back-pressure, FIFO fills, order preserved
        base_out = n_out;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 32'(i + 2);
            check("t2_in_ready", in_ready, 1);
            tick();
        end
        in_data = 32'd7;
        check("t2_full", in_ready, 0);
        repeat (40) tick();
        check("t2_full_held", in_ready, 0);
        check("t2_head_valid", out_valid, 1);
        check("t2_head_data", out_data, 1752);
        out_ready = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin tick(); k++; end
        check("t2_accept_bound", k < 50, 1);
        tick();
        in_valid = 1'b0;
        wait_idle("t2");
        check("t2_result_count", n_out - base_out, 6);

        // 3: key load refused during WAIT, accepted when idle
        in_valid = 1'b1; in_data = 32'd65;
        tick();
        in_valid = 1'b0;
        wait_start("t3");
        repeat (3) tick();
        key_load = 1'b1; key_exp = 32'd7; key_mod = 32'd77;
        tick();
        key_load = 1'b0;
        check("t3_no_ack", key_ack, 0);
        check("t3_mod_kept", core_mod, 3233);
        wait_idle("t3a");
        load_key(32'd7, 32'd77);
        in_valid = 1'b1; in_data = 32'd3;
        tick();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 200) begin tick(); k++; end
        check("t3_data", out_data, 31);
        check("t3_err", out_err, 0);
        wait_idle("t3b");

        // 4: core never answers -> timeout after 64 WAIT cycles
        load_key(32'd17, 32'd3233);
        core_dead = 1'b1;
        in_valid = 1'b1; in_data = 32'd65;
        tick();
        in_valid = 1'b0;
        wait_start("t4");
        k = 0;
        while (!out_valid && k < 200) begin tick(); k++; end
        check("t4_timeout_latency", k, 65);
        check("t4_data", out_data, 0);
        check("t4_err", out_err, 1);
        wait_idle("t4");
        core_dead = 1'b0;

        // 5: word equal to modulus, then degenerate modulus
        in_valid = 1'b1; in_data = 32'd3233;
        tick();
        in_valid = 1'b0;
        tick();                        // N+2
`ifdef RSA_RANGE_CHECK_EN
        check("t5_range_no_start", core_start, 0);
        check("t5_range_valid", out_valid, 1);
        check("t5_range_err", out_err, 1);
`else
        check("t5_norange_start", core_start, 1);
        check("t5_norange_base", core_base, 3233);
`endif
        wait_idle("t5a");
        load_key(32'd17, 32'd1);
        in_valid = 1'b1; in_data = 32'd5;
        tick();
        in_valid = 1'b0;
        tick();                        // N+2
        check("t5_badkey_no_start", core_start, 0);
        check("t5_badkey_valid", out_valid, 1);
        check("t5_badkey_err", out_err, 1);
        check("t5_badkey_data", out_data, 0);
        wait_idle("t5b");

        // 6: reset during WAIT with two queued words; late core_done ignored
        load_key(32'd17, 32'd3233);
        core_delay = 20;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 32'(65 + i);
            check("t6_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        wait_start("t6");
        repeat (5) tick();
        rst = 1'b1;
        rst_gen++;
        tick();
        rst = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_out_valid", out_valid, 0);
        check("t6_key_cleared", core_mod, 0);
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (out_valid || core_start || busy) seen = 1'b1;
        end
        check("t6_late_done_ignored", seen, 0);
        check("t6_queue_empty", q.size(), 0);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // global watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

endmodule
